// File: rtl/mem_arbiter_if.sv
// Requester, read-return and memory-port signals of the two-requester memory arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  a_req;
    logic                  b_req;
    logic                  a_we;
    logic                  b_we;
    logic                  a_lock;
    logic                  b_lock;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  a_gnt;
    logic                  b_gnt;
    logic                  a_rvalid;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  b_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output a_req, b_req, a_we, b_we, a_lock, b_lock,
        output a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, b_err,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  a_req, b_req, a_we, b_we, a_lock, b_lock,
        input  a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata, b_err,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded bus lock in front of a single-port data memory.
// Grants and memory drive are combinational; read-valid and the IO-protect error are registered.
module mem_arbiter #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = 16'h8000,
    parameter int unsigned           MAX_LOCK   = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {FREE, LOCK_A, LOCK_B} state_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    localparam logic [3:0] MAX_CNT  = 4'(MAX_LOCK);
    localparam bit         CAN_LOCK = (MAX_LOCK > 1);

    state_t                state_q, state_d;
    prio_t                 prio_q, prio_d;
    logic [3:0]            lock_cnt_q, lock_cnt_d;
    logic [3:0]            cnt_inc;
    logic                  win_a, win_b;
    logic                  b_protect;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [DATA_WIDTH-1:0] last_wdata_q;
    logic                  a_rvalid_q, b_rvalid_q, b_err_q;

    assign cnt_inc   = lock_cnt_q + 4'd1;
    assign b_protect = bus.b_we && (bus.b_addr == IO_ADDR);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        lock_cnt_d = lock_cnt_q;
        win_a      = 1'b0;
        win_b      = 1'b0;
        if (!reset) begin
            case (state_q)
                FREE: begin
                    win_a = bus.a_req && (!bus.b_req || prio_q == PRIO_A);
                    win_b = bus.b_req && !win_a;
                    if (win_a || win_b)
                        prio_d = win_a ? PRIO_B : PRIO_A;
                    if (CAN_LOCK && ((win_a && bus.a_lock) || (win_b && bus.b_lock))) begin
                        state_d    = win_a ? LOCK_A : LOCK_B;
                        lock_cnt_d = 4'd1;
                    end
                end
                LOCK_A: begin
                    win_a  = bus.a_req;
                    prio_d = PRIO_B;
                    // The grant that brings the count to MAX_LOCK is the last locked one.
                    if (bus.a_req && bus.a_lock && cnt_inc < MAX_CNT) begin
                        lock_cnt_d = cnt_inc;
                    end else begin
                        state_d    = FREE;
                        lock_cnt_d = '0;
                    end
                end
                LOCK_B: begin
                    win_b  = bus.b_req;
                    prio_d = PRIO_A;
                    if (bus.b_req && bus.b_lock && cnt_inc < MAX_CNT) begin
                        lock_cnt_d = cnt_inc;
                    end else begin
                        state_d    = FREE;
                        lock_cnt_d = '0;
                    end
                end
                default: state_d = FREE;
            endcase
        end
    end

    assign bus.a_gnt     = win_a;
    assign bus.b_gnt     = win_b;
    assign bus.mem_addr  = win_a ? bus.a_addr  : (win_b ? bus.b_addr  : last_addr_q);
    assign bus.mem_wdata = win_a ? bus.a_wdata : (win_b ? bus.b_wdata : last_wdata_q);
    assign bus.mem_we    = (win_a && bus.a_we) || (win_b && bus.b_we && !b_protect);
    assign bus.rdata     = bus.mem_rdata;
    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.b_err     = b_err_q;

    // NOTE: state uses non-blocking assignments and an asynchronous reset, so a mid-read reset drops the pending rvalid at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FREE;
            prio_q       <= PRIO_A;
            lock_cnt_q   <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            b_err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            if (win_a || win_b) begin
                last_addr_q  <= bus.mem_addr;
                last_wdata_q <= bus.mem_wdata;
            end
            a_rvalid_q <= win_a && !bus.a_we;
            b_rvalid_q <= win_b && !bus.b_we;
            b_err_q    <= win_b && b_protect;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one read/write port of the 64K x 16 data memory between the CPU load/store unit (requester A) and a peripheral master such as the IO/display engine (requester B). It sits directly in front of the memory port, muxes address, write data and write enable, and returns read data with a valid strobe to the requester that issued the read. Arbitration is round-robin with an optional bounded bus lock. Writes to the IO-enable word are restricted to requester A.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 16, memory address width
- IO_ADDR, 16'h8000, address of the IO-enable word; writable only by A
- MAX_LOCK, 4, maximum consecutive locked grants, range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_req, b_req  in  1 each  transaction request; held until granted
- a_we, b_we  in  1 each  1 = write, 0 = read; qualified by req
- a_lock, b_lock  in  1 each  request to keep ownership for the next cycle
- a_addr, b_addr  in  ADDR_WIDTH each  word address
- a_wdata, b_wdata  in  DATA_WIDTH each  write data
- a_gnt, b_gnt  out  1 each  combinational; transaction accepted this cycle
- a_rvalid, b_rvalid  out  1 each  registered; read data valid this cycle
- rdata  out  DATA_WIDTH  read data, shared by both requesters, qualified by x_rvalid
- b_err  out  1  registered one-cycle pulse: a write by B to IO_ADDR was dropped
- mem_addr  out  ADDR_WIDTH  to the memory port address
- mem_wdata  out  DATA_WIDTH  to the memory port write data
- mem_we  out  1  to the memory port write enable
- mem_rdata  in  DATA_WIDTH  from the memory port read data; valid one cycle after the address is captured

## Operation
- One transaction per cycle, at most one grant per cycle; a_gnt & b_gnt is never 1.
- Round-robin pointer `prio` (A or B):
  - Both requesting in FREE: the requester named by prio wins.
  - Single requester: it wins.
  - After any grant, prio points to the other requester.
- Lock FSM states:
  - FREE: arbitration as above.
  - If the winner also asserts its lock, go to LOCK_A or LOCK_B and set lock_cnt = 1.
  - LOCK_x: only x can be granted. If x deasserts req, grant nothing this cycle.
  - LOCK_x stays while x_req & x_lock & lock_cnt < MAX_LOCK; each grant increments lock_cnt.
  - Otherwise LOCK_x returns to FREE with prio = the other requester.
  - At lock_cnt == MAX_LOCK, a forced release happens. The next cycle is a FREE arbitration, and x cannot re-lock on that grant if the other requester is also requesting.
- Grant cycle: mem_addr, mem_wdata and mem_we are driven combinationally from the winner.
- No grant: mem_we = 0, and mem_addr/mem_wdata hold their last granted values.
- Protect rule: a write by B with b_addr == IO_ADDR is granted with mem_we forced to 0, and b_err pulses next cycle. A writes to IO_ADDR normally.
- Read return: a granted read sets an owner tag. In the next cycle x_rvalid = 1 and rdata = mem_rdata.
- Writes produce no rvalid.

## Timing
- Grant and memory drive happen in the same cycle (T). The memory captures the address/write at the end of cycle T.
- Read data is returned in cycle T+1. Back-to-back reads return on consecutive cycles, so the sustained rate is one read per cycle.
- Read-after-write to the same address in consecutive grants returns the new data, because the write completes at the end of T.
- Reset (asynchronous, any time), values while asserted and after release:
  - state = FREE, prio = A, lock_cnt = 0
  - a_rvalid = b_rvalid = 0, b_err = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = 0
  - rdata = mem_rdata (don't care while rvalid = 0)
- Reset asserted mid-read: the pending rvalid is dropped and never delivered.
- The first grant can occur in the first cycle after reset deasserts.

## Test plan
- After reset, a_req and b_req both read (a_addr = 5, b_addr = 9) continuously for 4 cycles -> grants go A, B, A, B. Each requester's rvalid arrives the following cycle with ram[5] / ram[9].
- A writes 16'h1234 to address 7, then reads 7 in the next cycle -> the read returns 16'h1234 with a_rvalid one cycle after its grant.
- B holds b_req & b_lock for 6 cycles while A requests, with MAX_LOCK = 4 -> B gets 4 consecutive grants, then A is granted, then B resumes.
- B writes 16'h0001 to 16'h8000 -> b_gnt = 1, mem_we = 0, b_err pulses for one cycle, and memory is unchanged. The same write by A -> mem_we = 1 and no b_err.
- Reset is asserted in the cycle after an A read grant -> a_rvalid stays 0, and all outputs take their reset values immediately, without waiting for a clock edge.
